// File: rtl/cr16_alu_pkg.sv
// cr16_alu_pkg: shared definitions for the CR16 execute unit.
//   op_e     - 4-bit opcode space; codes 11..15 are NOPs.
//   FLAG_*   - bit positions inside the 5-bit PSR {N,Z,F,L,C}.
//   state_e  - execute-unit FSM states.
package cr16_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADDC = 4'd1,
    OP_SUB  = 4'd2,
    OP_CMP  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_MOV  = 4'd7,
    OP_LSH  = 4'd8,
    OP_LUI  = 4'd9,
    OP_MUL  = 4'd10
  } op_e;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;
  localparam int NFLAGS = 5;

  typedef logic [NFLAGS-1:0] flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2
  } state_e;

  // MUL is the only opcode that occupies the unit for more than one cycle.
  function automatic logic is_multicycle(input op_e op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/regfile_param.sv
// regfile_param: NREGS x WIDTH general register file.
//   clk, reset            - clock, synchronous active-high clear of all registers
//   we, waddr, wdata      - synchronous write port
//   ra_addr/ra_data       - combinational read port A
//   rb_addr/rb_data       - combinational read port B
//   dbg_addr/dbg_data     - combinational debug read port
module regfile_param #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(NREGS)-1:0] ra_addr,
  output logic [WIDTH-1:0]         ra_data,
  input  logic [$clog2(NREGS)-1:0] rb_addr,
  output logic [WIDTH-1:0]         rb_data,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [WIDTH-1:0]         dbg_data
);

  logic [WIDTH-1:0] mem_q [NREGS];

  // NOTE: this array is cleared on reset because software relies on every
  // register reading zero afterwards; that forces flops instead of a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign ra_data  = mem_q[ra_addr];
  assign rb_data  = mem_q[rb_addr];
  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: CR16 execute stage (regfile, PSR flags, operand muxes, ALU,
// iterative shift-add multiplier) behind a valid/ready issue handshake.
//   clk, reset                 - clock, synchronous active-high reset
//   in_valid/in_ready          - issue handshake from decode
//   op, rdst, rsrc, immediate,
//   pc, im_sel, pc_sel         - instruction fields latched on accept
//   out_valid, out_wr, out_dst - one-cycle completion pulse and writeback info
//   alu_result, flags          - registered result and PSR {N,Z,F,L,C}
//   dbg_addr/dbg_data          - combinational register debug read
module alu_exec_unit #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               op,
  input  logic [$clog2(NREGS)-1:0] rdst,
  input  logic [$clog2(NREGS)-1:0] rsrc,
  input  logic [WIDTH-1:0]         immediate,
  input  logic [WIDTH-1:0]         pc,
  input  logic                     im_sel,
  input  logic                     pc_sel,
  output logic                     out_valid,
  output logic                     out_wr,
  output logic [$clog2(NREGS)-1:0] out_dst,
  output logic [WIDTH-1:0]         alu_result,
  output logic [4:0]               flags,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [WIDTH-1:0]         dbg_data
);

  import cr16_alu_pkg::*;

  localparam int AW = $clog2(NREGS);
  localparam int SW = $clog2(WIDTH);

  typedef logic [SW:0]   amt_t;  // signed shift amount, one bit wider than an index
  typedef logic [SW-1:0] cnt_t;  // multiply bit counter

  typedef struct packed {
    op_e             op;
    logic [AW-1:0]   rdst;
    logic [AW-1:0]   rsrc;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] pc;
    logic            im_sel;
    logic            pc_sel;
  } instr_t;

  state_e           state_q, state_d;
  instr_t           instr_q, instr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  cnt_t             cnt_q, cnt_d;
  flags_t           flags_q, flags_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic             out_wr_q, out_wr_d;
  logic [AW-1:0]    out_dst_q, out_dst_d;

  logic             accept;
  logic             rf_we;
  logic [WIDTH-1:0] rf_wdata;
  logic [WIDTH-1:0] rd_a, rd_b;
  logic [WIDTH-1:0] opa, opb;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] diff;
  logic             carry_in;
  amt_t             sh_amt, sh_mag;
  logic [WIDTH-1:0] lsh_res;
  logic [WIDTH-1:0] mul_sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_wr;
  flags_t           alu_flags;

  regfile_param #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (rf_we),
    .waddr    (instr_q.rdst),
    .wdata    (rf_wdata),
    .ra_addr  (instr_q.rdst),
    .ra_data  (rd_a),
    .rb_addr  (instr_q.rsrc),
    .rb_data  (rd_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // The multiplier owns the unit until it writes back; EXEC can overlap issue.
  assign in_ready = !reset && (state_q != ST_MUL);
  assign accept   = in_valid && in_ready;

  // Operands are read in the execute cycle, so a write at the previous edge
  // is already visible and dependent instructions need no forwarding.
  assign opa = instr_q.pc_sel ? instr_q.pc  : rd_a;
  assign opb = instr_q.im_sel ? instr_q.imm : rd_b;

  // ALU datapath
  // NOTE: every variable assigned in an always_comb gets a default at the top,
  // so no path through the case statements can leave a latch behind.
  always_comb begin
    carry_in  = (instr_q.op == OP_ADDC) ? flags_q[FLAG_C] : 1'b0;
    sum_ext   = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, carry_in};
    diff      = opa - opb;

    // Low SW+1 bits of B are a two's-complement shift count: >0 left, <0 right.
    sh_amt    = opb[SW:0];
    sh_mag    = sh_amt[SW] ? (~sh_amt + amt_t'(1)) : sh_amt;
    if (sh_mag >= amt_t'(WIDTH)) begin
      lsh_res = '0;
    end else if (sh_amt[SW]) begin
      lsh_res = opa >> sh_mag;
    end else begin
      lsh_res = opa << sh_mag;
    end

    // One shift-add step: add A<<i when bit i of B is set.
    mul_sum   = acc_q + (opb[cnt_q] ? (opa << cnt_q) : '0);

    alu_res   = result_q;
    alu_wr    = 1'b0;
    alu_flags = flags_q;

    case (instr_q.op)
      OP_ADD, OP_ADDC: begin
        alu_res           = sum_ext[WIDTH-1:0];
        alu_wr            = 1'b1;
        alu_flags[FLAG_C] = sum_ext[WIDTH];
        alu_flags[FLAG_F] = (opa[WIDTH-1] == opb[WIDTH-1]) &&
                            (sum_ext[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res           = diff;
        alu_wr            = 1'b1;
        alu_flags[FLAG_C] = opa < opb;
        alu_flags[FLAG_F] = (opa[WIDTH-1] != opb[WIDTH-1]) &&
                            (diff[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_CMP: begin
        alu_res           = diff;
        alu_flags[FLAG_L] = opa < opb;
        alu_flags[FLAG_Z] = opa == opb;
        alu_flags[FLAG_N] = $signed(opa) < $signed(opb);
      end
      OP_AND: begin alu_res = opa & opb;            alu_wr = 1'b1; end
      OP_OR:  begin alu_res = opa | opb;            alu_wr = 1'b1; end
      OP_XOR: begin alu_res = opa ^ opb;            alu_wr = 1'b1; end
      OP_MOV: begin alu_res = opb;                  alu_wr = 1'b1; end
      OP_LSH: begin alu_res = lsh_res;              alu_wr = 1'b1; end
      OP_LUI: begin alu_res = opb << (WIDTH / 2);   alu_wr = 1'b1; end
      default: ;  // NOP codes (and MUL, handled by the FSM) write nothing here
    endcase
  end

  // Control: next state, writeback and registered outputs
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    flags_d     = flags_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    out_wr_d    = 1'b0;
    out_dst_d   = out_dst_q;
    rf_we       = 1'b0;
    rf_wdata    = '0;

    unique case (state_q)
      ST_EXEC: begin
        out_valid_d = 1'b1;
        out_wr_d    = alu_wr;
        out_dst_d   = instr_q.rdst;
        flags_d     = alu_flags;
        result_d    = alu_res;
        rf_we       = alu_wr;
        rf_wdata    = alu_res;
        state_d     = ST_IDLE;
      end
      ST_MUL: begin
        acc_d = mul_sum;
        if (cnt_q == cnt_t'(WIDTH - 1)) begin
          out_valid_d = 1'b1;
          out_wr_d    = 1'b1;
          out_dst_d   = instr_q.rdst;
          result_d    = mul_sum;
          rf_we       = 1'b1;
          rf_wdata    = mul_sum;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      default: ;
    endcase

    // Accept only happens in IDLE/EXEC, so it never collides with MUL updates.
    if (accept) begin
      instr_d.op     = op_e'(op);
      instr_d.rdst   = rdst;
      instr_d.rsrc   = rsrc;
      instr_d.imm    = immediate;
      instr_d.pc     = pc;
      instr_d.im_sel = im_sel;
      instr_d.pc_sel = pc_sel;
      acc_d          = '0;
      cnt_d          = '0;
      state_d        = is_multicycle(op_e'(op)) ? ST_MUL : ST_EXEC;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      instr_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      flags_q     <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      out_wr_q    <= 1'b0;
      out_dst_q   <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      flags_q     <= flags_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      out_wr_q    <= out_wr_d;
      out_dst_q   <= out_dst_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_wr     = out_wr_q;
  assign out_dst    = out_dst_q;
  assign alu_result = result_q;
  assign flags      = flags_q;

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execute unit for the CR16 processor: register file, flags register, operand-select muxes and a multi-op ALU behind a valid/ready issue handshake. It is the next-generation execute stage, generalised in data width and register count, with registered writeback, a persistent PSR flags register, carry-in arithmetic and an iterative multi-cycle multiply. It sits between decode, which supplies opcode, register indices, immediate and PC, and the rest of the datapath.

## Interface
- WIDTH, 16, data width in bits; must be even, ≥ 8.
- NREGS, 16, number of general registers; power of two.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  unit can accept; transfer on in_valid && in_ready at the rising edge.
- op  in  4  opcode (cr16_alu_pkg).
- rdst  in  log2(NREGS)  destination / A-operand register.
- rsrc  in  log2(NREGS)  B-operand register.
- immediate  in  WIDTH  immediate operand.
- pc  in  WIDTH  PC value for A-operand substitution.
- im_sel  in  1  1: B = immediate; 0: B = R[rsrc].
- pc_sel  in  1  1: A = pc; 0: A = R[rdst].
- out_valid  out  1  one-cycle pulse: an instruction completed.
- out_wr  out  1  with out_valid: regfile was written.
- out_dst  out  log2(NREGS)  register written.
- alu_result  out  WIDTH  completed result (registered).
- flags  out  5  PSR {N,Z,F,L,C}, registered.
- dbg_addr  in  log2(NREGS)  debug read index.
- dbg_data  out  WIDTH  combinational R[dbg_addr].

## Operation
- Accept: op, rdst, rsrc, immediate, pc, im_sel, pc_sel latched into an instruction register.
- Execute cycle (the cycle after accept): operands read from regfile and flags register. Back-to-back dependent instructions need no forwarding.
- Ops: ADD A+B; ADDC A+B+C; SUB A−B; CMP (flags only, no write); AND; OR; XOR; MOV = B; LSH: shift A by signed low log2(WIDTH)+1 bits of B, positive left, negative logical right, |amount| ≥ WIDTH gives 0; LUI = B << WIDTH/2; MUL low WIDTH bits of A×B. All other codes are NOP: no write, flags unchanged, out_valid still pulses with out_wr=0.
- Flags: ADD/ADDC/SUB update C (carry out; SUB: borrow, A<B unsigned) and F (signed overflow); CMP updates L (A<B unsigned), Z (A==B), N (A<B signed). Other flags and other ops leave flags unchanged.
- Arithmetic is modulo 2^WIDTH. R0 is an ordinary register.
- FSM: IDLE (in_ready=1) –accept single-cycle op→ EXEC –1 cycle→ IDLE; IDLE –accept MUL→ MUL, shift-add one bit per cycle, WIDTH cycles, → IDLE.

## Timing
- Single-cycle op accepted at edge k: regfile/flags written at edge k+1, out_valid high for the cycle after k+1. in_ready stays 1, so a new instruction may be accepted at k+1 and sees the updated register and flags.
- MUL accepted at edge k: in_ready=0 from k to k+WIDTH; write and out_valid at edge k+WIDTH.
- Reset: all registers, flags, alu_result, out_dst cleared to 0. out_valid=0, out_wr=0, FSM=IDLE. in_ready=0 while reset is high.
- Reset mid-MUL or mid-EXEC aborts the instruction, with no writeback and no out_valid.
- in_valid while in_ready=0 is ignored; decode must hold it.
- dbg_data reflects a write from the cycle after the write edge.

## Structure
- Package cr16_alu_pkg: op codes ADD=0, ADDC=1, SUB=2, CMP=3, AND=4, OR=5, XOR=6, MOV=7, LSH=8, LUI=9, MUL=10; flag bit indices C=0, L=1, F=2, Z=3, N=4; FSM state enum.
- Sub-module regfile_param (WIDTH, NREGS): two combinational read ports, one synchronous write, reset clear, plus the debug read port.
- The ALU combinational logic and the multiply FSM stay in alu_exec_unit.

## Test plan
- Overflow: R1=0x7FFF, R2=0x0001, ADD rdst=1 rsrc=2 → R1=0x8000, F=1, C=0; out_valid one cycle after accept.
- Dependency chain: MOV R3←imm 0x00FF, then back-to-back ADD R3,R3 → R3=0x01FE, no stall between them.
- Carry chain: R4=0xFFFF, ADD R4+imm 1 → R4=0, C=1; next ADDC R5(=0)+imm 0 → R5=1.
- Compare: R6=0x8000, R7=0x0001, CMP → L=0, N=1, Z=0; no regfile write, out_wr=0.
- Multiply: R8=0x0123 × imm 0x0010 → R8=0x1230; in_ready low for exactly 16 cycles; in_valid held during the stall is not accepted.
- Reset mid-MUL: reset after 5 MUL cycles → no out_valid, R8=0 and flags=0 after reset, in_ready=1 the cycle after reset drops.
- LSH: R9=0x8001, imm 0xFFFF (−1) → 0x4000; imm 16 → 0.
